// File: rtl/rho_pkg.sv
// Shared definitions for the streaming Keccak rho-step unit.
// Holds the per-lane rho offset table, the lane index type, the output tag
// payload and small lane-counter helpers used by the rotator and its ROM.
package rho_pkg;

    localparam int unsigned RHO_NUM_LANES  = 25;
    localparam int unsigned RHO_LANE_IDX_W = 5;
    localparam int unsigned RHO_OFF_RAW_W  = 6;

    typedef logic [RHO_LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [RHO_OFF_RAW_W-1:0]  rho_off_raw_t;

    // Rho offsets in the encoder's lane order (full 64-bit amounts).
    localparam rho_off_raw_t RHO_OFFSETS [RHO_NUM_LANES] = '{
        6'd21, 6'd8,  6'd41, 6'd45, 6'd15,
        6'd56, 6'd14, 6'd18, 6'd2,  6'd61,
        6'd28, 6'd27, 6'd0,  6'd1,  6'd62,
        6'd55, 6'd20, 6'd36, 6'd44, 6'd6,
        6'd25, 6'd39, 6'd3,  6'd10, 6'd43
    };

    // Sideband carried alongside a rotated lane in the output register.
    typedef struct packed {
        lane_idx_t lane;
        logic      last;
    } rho_tag_t;

    // True when the lane is the final one of a frame of num_lanes lanes.
    function automatic logic rho_is_last(input lane_idx_t lane, input int unsigned num_lanes);
        return lane == RHO_LANE_IDX_W'(num_lanes - 1);
    endfunction

    // Next lane index, wrapping to 0 after the final lane of a frame.
    function automatic lane_idx_t rho_next_lane(input lane_idx_t lane, input int unsigned num_lanes);
        lane_idx_t nxt;
        if (rho_is_last(lane, num_lanes)) begin
            nxt = '0;
        end else begin
            nxt = lane + RHO_LANE_IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rho_offset_rom.sv
// Combinational rho offset lookup.
// Maps a lane index to its rho offset reduced modulo LANE_W (low OFF_W bits).
// Ports:
//   lane     - lane index 0..24; indices 25..31 return 0
//   offset_c - reduced rotate amount (combinational)
module rho_offset_rom
    import rho_pkg::*;
#(
    parameter int unsigned LANE_W = 64
) (
    input  lane_idx_t                    lane,
    output logic [$clog2(LANE_W)-1:0]    offset_c
);

    localparam int unsigned OFF_W = $clog2(LANE_W);

    // Truncating to OFF_W bits is the mod-LANE_W reduction for a power-of-two lane.
    always_comb begin
        offset_c = '0;
        for (int unsigned i = 0; i < RHO_NUM_LANES; i++) begin
            if (lane == RHO_LANE_IDX_W'(i)) begin
                offset_c = OFF_W'(RHO_OFFSETS[i]);
            end
        end
    end

endmodule

// File: rtl/rho_lane_rotator.sv
// Streaming Keccak rho-step unit between theta and pi.
// Accepts one lane per handshake in frame order, rotates it by its rho offset
// (left for forward rho, right for inverse rho) and presents it one cycle
// later from a single output register with pass-through on simultaneous drain.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input lane handshake; in_ready = !out_valid || out_ready
//   in_data           - lane value (LANE_W bits)
//   in_inv            - 0 rotate left, 1 rotate right; sampled per lane
//   out_valid/out_ready - output handshake
//   out_data          - rotated lane
//   out_lane          - lane index of out_data
//   out_last          - out_data is the final lane of its frame
//   frame_done        - one-cycle pulse after the final lane leaves downstream
module rho_lane_rotator
    import rho_pkg::*;
#(
    parameter int unsigned LANE_W    = 64,
    parameter int unsigned OFF_W     = $clog2(LANE_W),
    parameter int unsigned NUM_LANES = RHO_NUM_LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [4:0]        out_lane,
    output logic              out_last,
    output logic              frame_done
);

    // Elaboration-time parameter sanity.
    if ((LANE_W & (LANE_W - 1)) != 0 || LANE_W < 8 || LANE_W > 64) begin : g_bad_lane_w
        $error("rho_lane_rotator: LANE_W must be a power of two in 8..64");
    end
    if (OFF_W != $clog2(LANE_W)) begin : g_bad_off_w
        $error("rho_lane_rotator: OFF_W must equal clog2(LANE_W)");
    end
    if (NUM_LANES < 2 || NUM_LANES > RHO_NUM_LANES) begin : g_bad_num_lanes
        $error("rho_lane_rotator: NUM_LANES out of range");
    end

    localparam int unsigned DBL_W = 2 * LANE_W;

    // Registered state.
    lane_idx_t         lane_cnt;
    logic              valid_q;
    logic [LANE_W-1:0] data_q;
    rho_tag_t          tag_q;
    logic              done_q;

    // Next-state values.
    lane_idx_t         lane_cnt_nxt;
    logic              valid_nxt;
    logic [LANE_W-1:0] data_nxt;
    rho_tag_t          tag_nxt;
    logic              done_nxt;

    logic              in_fire_c;
    logic              out_fire_c;
    logic              cnt_last_c;
    logic [OFF_W-1:0]  off_c;
    logic [DBL_W-1:0]  dbl_c;
    logic [DBL_W-1:0]  rotl_wide_c;
    logic [DBL_W-1:0]  rotr_wide_c;
    logic [LANE_W-1:0] rot_c;

    // Handshake: one output slot, refillable in the same cycle it drains.
    assign in_ready   = !valid_q || out_ready;
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = valid_q && out_ready;
    assign cnt_last_c = rho_is_last(lane_cnt, NUM_LANES);

    // Offset for the lane currently expected at the input.
    rho_offset_rom #(
        .LANE_W (LANE_W)
    ) u_offset_rom (
        .lane     (lane_cnt),
        .offset_c (off_c)
    );

    // Rotate via a doubled word so an offset of 0 never needs a LANE_W-bit shift.
    always_comb begin
        dbl_c       = {in_data, in_data};
        rotl_wide_c = dbl_c << off_c;
        rotr_wide_c = dbl_c >> off_c;
        rot_c       = in_inv ? rotr_wide_c[LANE_W-1:0] : rotl_wide_c[DBL_W-1:LANE_W];
    end

    // Next-state: load on accept, clear on drain-only, hold under backpressure.
    always_comb begin
        lane_cnt_nxt = lane_cnt;
        valid_nxt    = valid_q;
        data_nxt     = data_q;
        tag_nxt      = tag_q;
        done_nxt     = out_fire_c && tag_q.last;

        if (in_fire_c) begin
            valid_nxt    = 1'b1;
            data_nxt     = rot_c;
            tag_nxt.lane = lane_cnt;
            tag_nxt.last = cnt_last_c;
            lane_cnt_nxt = rho_next_lane(lane_cnt, NUM_LANES);
        end else if (out_fire_c) begin
            valid_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            tag_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            lane_cnt <= lane_cnt_nxt;
            valid_q  <= valid_nxt;
            data_q   <= data_nxt;
            tag_q    <= tag_nxt;
            done_q   <= done_nxt;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_lane   = tag_q.lane;
    assign out_last   = tag_q.last;
    assign frame_done = done_q;

    // Stalled output must not change underneath the downstream stage.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (rst)
        (valid_q && !out_ready) |=> (valid_q && $stable(data_q) && $stable(tag_q))
    );

    // The lane counter never leaves the frame.
    a_cnt_range : assert property (
        @(posedge clk) disable iff (rst)
        lane_cnt < RHO_LANE_IDX_W'(NUM_LANES)
    );

    // frame_done is a single-cycle pulse.
    a_done_pulse : assert property (
        @(posedge clk) disable iff (rst)
        done_q |=> !done_q
    );

endmodule
